// File: rtl/fetch_stage.sv
// Instruction fetch stage: IDLE/REQ/WAIT request FSM with one outstanding request,
// branch redirect with kill of the in-flight response, and a registered decode output.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  fetch_sel,
  input  logic        nop_output_fetch,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instr_fetch,
  output logic [31:0] pc_fetch,
  output logic [6:0]  opcode_fetch,
  output logic        fetch_valid
);

  localparam logic [1:0] FETCH_SEL_PC     = 2'b00;
  localparam logic [1:0] FETCH_SEL_NOP    = 2'b01;
  localparam logic [1:0] FETCH_SEL_BRANCH = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_fetch_q, pc_fetch_d;
  logic        valid_q, valid_d;

  logic branch_s, handshake_s, complete_s, good_s;

  assign branch_s    = (fetch_sel == FETCH_SEL_BRANCH);
  assign handshake_s = (state_q == S_REQ) && req_valid_q && imem_req_ready;
  assign complete_s  = (state_q == S_WAIT) && imem_resp_valid;
  // A redirect arriving together with the response kills it just like a pending kill.
  assign good_s      = complete_s && !kill_q && !branch_s;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    instr_d     = NOP_INSTR;
    valid_d     = 1'b0;
    pc_fetch_d  = pc_fetch_q;

    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   state_d = handshake_s ? S_WAIT : S_REQ;
      S_WAIT:  state_d = complete_s ? S_REQ : S_WAIT;
      default: state_d = S_IDLE;
    endcase

    if (complete_s) begin
      kill_d = 1'b0;
    end else if (branch_s && ((state_q == S_WAIT) || handshake_s)) begin
      kill_d = 1'b1;
    end else begin
      kill_d = kill_q;
    end

    case (fetch_sel)
      FETCH_SEL_BRANCH: pc_d = branch_target;
      FETCH_SEL_PC:     pc_d = good_s ? (pc_q + 32'd4) : pc_q;
      FETCH_SEL_NOP:    pc_d = pc_q;
      default:          pc_d = pc_q;
    endcase

    if (good_s) begin
      pc_fetch_d = pc_q;
      if (nop_output_fetch) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else begin
        instr_d = imem_resp_data;
        valid_d = 1'b1;
      end
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end

    req_valid_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      instr_q     <= NOP_INSTR;
      pc_fetch_q  <= RESET_PC;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      req_valid_q <= req_valid_d;
      instr_q     <= instr_d;
      pc_fetch_q  <= pc_fetch_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign instr_fetch    = instr_q;
  assign pc_fetch       = pc_fetch_q;
  assign opcode_fetch   = instr_q[6:0];
  assign fetch_valid    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Random-stimulus bench for fetch_stage against a transaction-level model that tracks
// outstanding requests as a queue of (address, killed) entries.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [1:0]  SEL_PC = 2'b00;
  localparam logic [1:0]  SEL_NOP = 2'b01;
  localparam logic [1:0]  SEL_BR = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  fetch_sel;
  logic        nop_output_fetch;
  logic [31:0] branch_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instr_fetch;
  logic [31:0] pc_fetch;
  logic [6:0]  opcode_fetch;
  logic        fetch_valid;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .fetch_sel(fetch_sel), .nop_output_fetch(nop_output_fetch),
    .branch_target(branch_target), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_fetch(instr_fetch), .pc_fetch(pc_fetch), .opcode_fetch(opcode_fetch),
    .fetch_valid(fetch_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          killed;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] m_pc, m_instr, m_pcf;
  bit          m_first, m_valid;
  bit          late_rv;
  int          wrap_hits = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_pc    = RST_PC;
    m_first = 1'b1;
    m_instr = NOP;
    m_pcf   = RST_PC;
    m_valid = 1'b0;
  endtask

  task automatic compare_outputs(input string pfx);
    bit exp_rv;
    exp_rv = !m_first && (pend.size() == 0);
    check_eq({pfx, "req_valid"}, {31'b0, imem_req_valid}, {31'b0, exp_rv});
    check_eq({pfx, "req_addr"},  imem_req_addr, m_pc);
    check_eq({pfx, "instr"},     instr_fetch, m_instr);
    check_eq({pfx, "pc_fetch"},  pc_fetch, m_pcf);
    check_eq({pfx, "opcode"},    {25'b0, opcode_fetch}, {25'b0, m_instr[6:0]});
    check_eq({pfx, "valid"},     {31'b0, fetch_valid}, {31'b0, m_valid});
  endtask

  // Pick random inputs for the coming edge and advance the model across it.
  task automatic drive_and_model();
    int    r;
    bit    exp_rv, branch, good;
    pend_t e;
    r = $urandom_range(0, 99);
    fetch_sel = (r < 75) ? SEL_PC : (r < 85) ? SEL_BR : (r < 93) ? SEL_NOP : 2'b11;
    branch_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
    nop_output_fetch = ($urandom_range(0, 9) == 0);
    imem_req_ready   = ($urandom_range(0, 2) != 0);
    imem_resp_valid  = late_rv ? 1'b1 : ($urandom_range(0, 2) != 0);
    late_rv = 1'b0;
    imem_resp_data   = (pend.size() > 0) ? mem_word(pend[0].addr) : $urandom;

    exp_rv = !m_first && (pend.size() == 0);
    branch = (fetch_sel == SEL_BR);
    good   = 1'b0;
    m_instr = NOP;
    m_valid = 1'b0;
    if (pend.size() > 0 && imem_resp_valid) begin
      e = pend.pop_front();
      if (!(e.killed || branch)) begin
        good  = 1'b1;
        m_pcf = e.addr;
        if (!nop_output_fetch) begin
          m_instr = mem_word(e.addr);
          m_valid = 1'b1;
        end
      end
    end else if (pend.size() > 0 && branch) begin
      pend[0].killed = 1'b1;
    end
    if (exp_rv && imem_req_ready) pend.push_back('{addr: m_pc, killed: branch});
    if (good && fetch_sel == SEL_PC && m_pc == 32'hFFFF_FFFC) wrap_hits++;
    if (branch)                         m_pc = branch_target;
    else if (good && fetch_sel == SEL_PC) m_pc = m_pc + 32'd4;
    m_first = 1'b0;
  endtask

  initial begin
    int resets;
    resets = 0;
    late_rv = 1'b0;
    rst = 1'b1;
    fetch_sel = SEL_PC;
    nop_output_fetch = 1'b0;
    branch_target = 32'h0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_outputs("reset_");
    rst = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      compare_outputs("");
      if (((i >= 1000 && resets == 0) || (i >= 2500 && resets == 1)) && pend.size() > 0) begin
        // Asynchronous reset with a request outstanding; a late response follows release.
        resets++;
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_outputs("async_rst_");
        imem_resp_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        late_rv = 1'b1;
        compare_outputs("post_rst_");
      end
      drive_and_model();
      @(negedge clk);
    end

    check_eq("resets_applied", resets, 2);
    check_eq("pc_wrap_seen", {31'b0, (wrap_hits > 0)}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
